// File: rtl/clk_step_ctrl_pkg.sv
// Shared definitions for the run/step/halt clock-enable sequencer.
// State encodings double as the LED/display code driven on the state port.
package clk_step_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_BURST = 2'd2
  } state_t;

  localparam int DEB_CYCLES_DEF = 16;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: two-flop synchroniser, stability counter and a one-cycle
// pulse on each debounced rising edge. Reusable for any board push-button.
module btn_debounce
  import clk_step_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic rise
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  logic             sync0_reg;
  logic             sync1_reg;
  logic             level_reg;
  logic [CNT_W-1:0] stable_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync0_reg      <= 1'b0;
      sync1_reg      <= 1'b0;
      level_reg      <= 1'b0;
      stable_cnt_reg <= '0;
      rise           <= 1'b0;
    end else begin
      sync0_reg <= btn;
      sync1_reg <= sync0_reg;
      rise      <= 1'b0;
      // Count consecutive samples that disagree with the current level; any
      // agreeing sample (a bounce back) restarts the count.
      if (sync1_reg == level_reg) begin
        stable_cnt_reg <= '0;
      end else if (stable_cnt_reg == CNT_W'(DEB_CYCLES - 1)) begin
        level_reg      <= sync1_reg;
        stable_cnt_reg <= '0;
        rise           <= sync1_reg;
      end else begin
        stable_cnt_reg <= stable_cnt_reg + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/clk_step_ctrl.sv
// Run/step/halt sequencer: turns the free-running board clock into a one-cycle
// cpu_ce pulse train for free-run, N-step bursts and breakpoint halts.
module clk_step_ctrl
  import clk_step_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int DIV_W      = 32,
  parameter int BURST_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run_mode,
  input  logic               step_btn,
  input  logic               halt_req,
  input  logic [DIV_W-1:0]   div,
  input  logic [BURST_W-1:0] burst_n,
  output logic               cpu_ce,
  output logic [1:0]         state,
  output logic [31:0]        cycle_cnt,
  output logic               run_blocked
);

  state_t             state_reg;
  logic [DIV_W-1:0]   div_cnt_reg;
  logic [BURST_W-1:0] remaining_reg;
  logic               step_evt;
  logic               tick;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step_deb (
    .clk   (clk),
    .reset (reset),
    .btn   (step_btn),
    .rise  (step_evt)
  );

  // div is compared live; a shrinking div lets the counter run on to wrap.
  assign tick  = (state_reg != ST_HALT) && (div_cnt_reg == div);
  assign state = state_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_HALT;
      cpu_ce        <= 1'b0;
      cycle_cnt     <= '0;
      run_blocked   <= 1'b0;
      div_cnt_reg   <= '0;
      remaining_reg <= '0;
    end else begin
      cpu_ce <= tick;
      if (cpu_ce)
        cycle_cnt <= cycle_cnt + 32'd1;
      div_cnt_reg <= tick ? '0 : div_cnt_reg + DIV_W'(1);

      case (state_reg)
        ST_HALT: begin
          div_cnt_reg <= '0;
          if (!run_mode)
            run_blocked <= 1'b0;
          if (run_mode && !run_blocked) begin
            state_reg <= ST_RUN;
          end else if (step_evt && !run_mode) begin
            state_reg     <= ST_BURST;
            remaining_reg <= (burst_n == '0) ? BURST_W'(1) : burst_n;
          end
        end
        ST_RUN: begin
          // A tick coinciding with halt_req still yields its cpu_ce above.
          if (halt_req) begin
            state_reg   <= ST_HALT;
            run_blocked <= 1'b1;
            div_cnt_reg <= '0;
          end else if (!run_mode) begin
            state_reg   <= ST_HALT;
            div_cnt_reg <= '0;
          end
        end
        ST_BURST: begin
          if (tick) begin
            remaining_reg <= remaining_reg - BURST_W'(1);
            if (remaining_reg == BURST_W'(1)) begin
              state_reg   <= ST_HALT;
              div_cnt_reg <= '0;
            end
          end
        end
        default: begin
          state_reg   <= ST_HALT;
          div_cnt_reg <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_step_ctrl.sv
// Directed, table-driven bench for clk_step_ctrl: run rates, burst lengths,
// bounce rejection, breakpoint halt, reset mid-burst and counter wrap.
module tb_clk_step_ctrl;

  logic        clk = 1'b0;
  logic        reset, run_mode, step_btn, halt_req;
  logic [31:0] div;
  logic [15:0] burst_n;
  logic        cpu_ce;
  logic [1:0]  state;
  logic [31:0] cycle_cnt;
  logic        run_blocked;

  clk_step_ctrl #(.DEB_CYCLES(16), .DIV_W(32), .BURST_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .run_mode    (run_mode),
    .step_btn    (step_btn),
    .halt_req    (halt_req),
    .div         (div),
    .burst_n     (burst_n),
    .cpu_ce      (cpu_ce),
    .state       (state),
    .cycle_cnt   (cycle_cnt),
    .run_blocked (run_blocked)
  );

  always #5 clk = ~clk;

  typedef struct { int dv; int n; int exp_p; } run_vec_t;
  typedef struct { int dv; int bn; int exp_p; } burst_vec_t;

  int errors = 0;
  int checks = 0;
  int pulses, gap_bad, last_pulse, cyc, exp_gap, burst_entries, mism, win_pulses;
  logic [1:0]  prev_state;
  logic [31:0] base;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Advance one clock and sample outputs on the falling edge.
  task automatic clk_step();
    @(negedge clk);
    cyc++;
    if (cpu_ce) begin
      if (exp_gap != 0 && last_pulse >= 0 && (cyc - last_pulse) != exp_gap)
        gap_bad++;
      last_pulse = cyc;
      pulses++;
    end
    if (state == 2'd2 && prev_state != 2'd2)
      burst_entries++;
    prev_state = state;
  endtask

  task automatic clear_stats();
    pulses = 0; gap_bad = 0; last_pulse = -1; burst_entries = 0; exp_gap = 0;
  endtask

  run_vec_t   run_tab[5];
  burst_vec_t burst_tab[5];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // pulses land at steps 1+m*(div+1), counting the entry observation as step 1
    run_tab[0] = '{0, 10, 9};
    run_tab[1] = '{3, 13, 3};
    run_tab[2] = '{1,  7, 3};
    run_tab[3] = '{9, 25, 2};
    run_tab[4] = '{2,  4, 1};
    burst_tab[0] = '{1, 5, 5};
    burst_tab[1] = '{0, 0, 1};
    burst_tab[2] = '{2, 3, 3};
    burst_tab[3] = '{0, 4, 4};
    burst_tab[4] = '{3, 1, 1};

    cyc = 0; prev_state = 2'd0; clear_stats();
    reset = 1'b1; run_mode = 1'b0; step_btn = 1'b0; halt_req = 1'b0;
    div = 32'd0; burst_n = 16'd1;
    repeat (3) clk_step();
    check("reset_state", 32'(state), 32'd0);
    check("reset_cpu_ce", 32'(cpu_ce), 32'd0);
    check("reset_cycle_cnt", cycle_cnt, 32'd0);
    check("reset_run_blocked", 32'(run_blocked), 32'd0);
    reset = 1'b0;
    clk_step();

    // Free run at div=3: pulses at 4, 8, 12 cycles after entry.
    div = 32'd3; run_mode = 1'b1;
    clk_step();
    check("run_entry_state", 32'(state), 32'd1);
    mism = 0;
    for (int k = 1; k <= 12; k++) begin
      clk_step();
      if (cpu_ce !== ((k % 4) == 0)) mism++;
    end
    check("run_div3_pattern_mism", 32'(mism), 32'd0);
    run_mode = 1'b0;
    clk_step();
    check("run_stop_state", 32'(state), 32'd0);
    check("run_div3_cycle_cnt", cycle_cnt, 32'd3);
    clear_stats();
    repeat (8) clk_step();
    check("halt_no_ce", 32'(pulses), 32'd0);

    foreach (run_tab[i]) begin
      base = cycle_cnt;
      div = 32'(run_tab[i].dv);
      clear_stats();
      exp_gap = run_tab[i].dv + 1;
      run_mode = 1'b1;
      repeat (run_tab[i].n) clk_step();
      win_pulses = pulses;
      check($sformatf("run_tab%0d_pulses", i), 32'(win_pulses), 32'(run_tab[i].exp_p));
      check($sformatf("run_tab%0d_gap", i), 32'(gap_bad), 32'd0);
      run_mode = 1'b0;
      repeat (3) clk_step();
      check($sformatf("run_tab%0d_halt", i), 32'(state), 32'd0);
      check($sformatf("run_tab%0d_cnt", i), cycle_cnt - base, 32'(pulses));
    end

    foreach (burst_tab[i]) begin
      base = cycle_cnt;
      div = 32'(burst_tab[i].dv);
      burst_n = 16'(burst_tab[i].bn);
      clear_stats();
      exp_gap = burst_tab[i].dv + 1;
      step_btn = 1'b1;
      for (int t = 0; t < 120; t++) begin
        if (t == 30) step_btn = 1'b0;
        clk_step();
      end
      check($sformatf("burst%0d_pulses", i), 32'(pulses), 32'(burst_tab[i].exp_p));
      check($sformatf("burst%0d_gap", i), 32'(gap_bad), 32'd0);
      check($sformatf("burst%0d_entries", i), 32'(burst_entries), 32'd1);
      check($sformatf("burst%0d_cnt", i), cycle_cnt - base, 32'(burst_tab[i].exp_p));
      check($sformatf("burst%0d_end_state", i), 32'(state), 32'd0);
    end

    // Bouncing press and bouncing release: one event, one 2-step burst.
    div = 32'd0; burst_n = 16'd2; base = cycle_cnt;
    clear_stats();
    for (int t = 0; t < 40; t++) begin step_btn = ((t / 3) % 2) == 0; clk_step(); end
    step_btn = 1'b1;
    repeat (40) clk_step();
    for (int t = 0; t < 40; t++) begin step_btn = ((t / 3) % 2) != 0; clk_step(); end
    step_btn = 1'b0;
    repeat (40) clk_step();
    check("bounce_entries", 32'(burst_entries), 32'd1);
    check("bounce_pulses", 32'(pulses), 32'd2);
    check("bounce_cnt", cycle_cnt - base, 32'd2);

    // Breakpoint during div=0 run.
    div = 32'd0; run_mode = 1'b1;
    clear_stats();
    repeat (5) clk_step();
    check("brk_run_pulses", 32'(pulses), 32'd4);
    halt_req = 1'b1;
    clk_step();
    halt_req = 1'b0;
    check("brk_last_ce", 32'(cpu_ce), 32'd1);
    check("brk_state", 32'(state), 32'd0);
    check("brk_blocked", 32'(run_blocked), 32'd1);
    clk_step();
    check("brk_ce_off", 32'(cpu_ce), 32'd0);
    clear_stats();
    step_btn = 1'b1;
    repeat (25) clk_step();
    step_btn = 1'b0;
    repeat (20) clk_step();
    check("brk_blocked_pulses", 32'(pulses), 32'd0);
    check("brk_step_ignored", 32'(burst_entries), 32'd0);
    check("brk_stays_halt", 32'(state), 32'd0);
    run_mode = 1'b0;
    clk_step();
    check("brk_unblock", 32'(run_blocked), 32'd0);
    run_mode = 1'b1;
    clk_step();
    check("brk_rerun_state", 32'(state), 32'd1);
    run_mode = 1'b0;
    repeat (3) clk_step();

    // Reset with remaining=3 in a 6-step burst.
    div = 32'd1; burst_n = 16'd6;
    clear_stats();
    step_btn = 1'b1;
    for (int t = 0; t < 60 && state != 2'd2; t++) clk_step();
    check("rst_burst_started", 32'(state), 32'd2);
    step_btn = 1'b0;
    for (int t = 0; t < 40 && pulses < 3; t++) clk_step();
    check("rst_pre_pulses", 32'(pulses), 32'd3);
    reset = 1'b1;
    clk_step();
    check("rst_mid_state", 32'(state), 32'd0);
    check("rst_mid_ce", 32'(cpu_ce), 32'd0);
    check("rst_mid_cnt", cycle_cnt, 32'd0);
    reset = 1'b0;
    clear_stats();
    repeat (40) clk_step();
    check("rst_after_pulses", 32'(pulses), 32'd0);
    check("rst_after_cnt", cycle_cnt, 32'd0);

    // Wrap of the issued-pulse counter.
    force dut.cycle_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.cycle_cnt;
    check("wrap_preset", cycle_cnt, 32'hFFFF_FFFE);
    div = 32'd2; run_mode = 1'b1;
    clear_stats();
    for (int t = 0; t < 30 && pulses < 3; t++) clk_step();
    run_mode = 1'b0;
    clk_step();
    check("wrap_pulses", 32'(pulses), 32'd3);
    check("wrap_cnt", cycle_cnt, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
